module_bin_to_bcd_seq: RTL and testbench
========================================

Name: module_bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. A start/busy/done handshake replaces the single-cycle combinational conversion, so wide inputs close timing easily. An overflow flag reports when N_DIG digits cannot hold the result. It feeds the display/readout path.

Parameters:
W_BIN, 12, input binary width in bits (>=1)
N_DIG, 4, number of BCD output digits (>=1); output width is 4*N_DIG

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_start  input  1  conversion request; sampled only in IDLE
i_bin  input  W_BIN  unsigned binary operand; captured on the accepted i_start edge
o_busy  output  1  high while a conversion is in progress (SHIFT state)
o_done  output  1  one-cycle pulse: o_bcd/o_ovf updated this cycle
o_bcd  output  4*N_DIG  packed BCD result, digit 0 in [3:0]; held until the next o_done
o_ovf  output  1  result exceeded 10^N_DIG-1; held with o_bcd

Behaviour:
- Reset (asynchronous assert, any time including mid-conversion): state=IDLE, o_busy=0, o_done=0, o_bcd=0, o_ovf=0, internal shift/BCD/counter registers cleared. Any in-flight conversion is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: if i_start=1 at an edge, latch i_bin into the shift register, clear the working BCD register and sticky overflow, load the bit counter with W_BIN, go to SHIFT. Otherwise stay.
- SHIFT (o_busy=1), one step per edge:
  - Correct every digit of the working register: digit>=5 -> digit+3 (4-bit, all digits in parallel, on pre-shift values).
  - Shift the working register left by 1; the shift-register MSB enters BCD bit 0; shift register shifts left by 1.
  - The bit leaving BCD bit 4*N_DIG-1 ORs into the sticky overflow.
  - Decrement the counter; when the step that brings it to 0 completes, go to DONE.
- DONE (one cycle): o_bcd <= working register, o_ovf <= sticky overflow, o_done=1, o_busy=0; next state IDLE.
- Latency: i_start accepted at edge 0; SHIFT occupies edges 1..W_BIN; o_done high during the cycle after edge W_BIN+1. Throughput: one conversion per W_BIN+2 cycles.
- i_start while in SHIFT or DONE is ignored (no queuing); i_bin changes after capture have no effect.
- On overflow, o_bcd holds the value mod 10^N_DIG (correct low digits) and o_ovf=1. With defaults (12 bits, 4 digits) o_ovf is never set.
- Counter width is $clog2(W_BIN+1). All outputs are registered; no combinational input-to-output path.
- o_bcd/o_ovf change only in DONE or on reset.

Test Plan:
- Defaults, i_bin=4095, i_start pulse -> o_busy high for 12 cycles, o_done one cycle later, o_bcd=16'h4095, o_ovf=0.
- Defaults, i_bin=0, then 1000, then 9 back-to-back (each start issued in IDLE) -> o_bcd=16'h0000, 16'h1000, 16'h0009 respectively; each o_done exactly one cycle wide.
- Defaults, start i_bin=1234, pulse i_start with i_bin=999 during SHIFT -> only one o_done, o_bcd=16'h1234; second request ignored.
- Defaults, assert i_rst at SHIFT step 6 of i_bin=4000 -> all outputs 0 immediately (asynchronously); no o_done; a fresh start of 42 afterwards gives o_bcd=16'h0042.
- W_BIN=8, N_DIG=2: i_bin=255 -> o_bcd=8'h55, o_ovf=1; then i_bin=99 -> o_bcd=8'h99, o_ovf=0.
- Randomised sweep across the full 12-bit range against a reference model: o_bcd always matches the decimal digits, latency always W_BIN+2 edges.

Source files
------------

// File: rtl/module_bin_to_bcd_seq.sv
// rtl/module_bin_to_bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
//
// Converts an unsigned W_BIN-bit operand into N_DIG packed BCD digits. The
// conversion takes one input bit per clock, so wide operands do not need a
// deep combinational adder chain.
//
// Parameters:
//   W_BIN   input binary width in bits (>=1)
//   N_DIG   number of BCD digits produced (>=1); o_bcd is 4*N_DIG bits wide
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    asynchronous active-high reset; discards any in-flight conversion
//   i_start  conversion request, only looked at while idle
//   i_bin    operand, captured on the edge that accepts i_start
//   o_busy   high while the shift steps run
//   o_done   one-cycle pulse marking the cycle o_bcd/o_ovf were updated
//   o_bcd    packed BCD result, digit 0 in [3:0]; held until the next o_done
//   o_ovf    result did not fit in N_DIG digits; held alongside o_bcd

module module_bin_to_bcd_seq #(
    parameter int W_BIN = 12,
    parameter int N_DIG = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [W_BIN-1:0]     i_bin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*N_DIG-1:0]   o_bcd,
    output logic                 o_ovf
);

    localparam int BCD_W = 4 * N_DIG;
    localparam int CNT_W = $clog2(W_BIN + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W_BIN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [W_BIN-1:0]   shift_reg;   // remaining operand bits, MSB consumed first
    logic [BCD_W-1:0]   bcd_work;    // working BCD accumulator
    logic [CNT_W-1:0]   cnt;         // shift steps still to run
    logic               ovf_sticky;  // any bit ever pushed out of the top digit

    logic [BCD_W-1:0]   bcd_adj;     // accumulator after the add-3 correction
    logic [BCD_W-1:0]   bcd_next;    // accumulator after correction and shift
    logic [W_BIN-1:0]   shift_next;
    logic [3:0]         digit;

    // Per-digit add-3 correction on the pre-shift values. A digit of 5..9
    // becomes 8..12 so that doubling it carries correctly into the next
    // digit. All digits are corrected in parallel.
    always_comb begin
        bcd_adj = '0;
        digit   = '0;
        for (int d = 0; d < N_DIG; d++) begin
            digit = bcd_work[4*d +: 4];
            bcd_adj[4*d +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
        end
    end

    // The operand MSB enters the bottom of the accumulator. The top bit of the
    // corrected accumulator is the carry out of the highest digit; it is
    // dropped from the result and folded into the sticky overflow instead.
    // Lower digits never depend on higher ones, so the kept digits are the
    // result modulo 10^N_DIG.
    always_comb begin
        bcd_next   = {bcd_adj[BCD_W-2:0], shift_reg[W_BIN-1]};
        shift_next = shift_reg << 1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bcd_work   <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_bcd      <= '0;
            o_ovf      <= 1'b0;
        end else begin
            // o_done is a pulse: only the DONE edge raises it.
            o_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        shift_reg  <= i_bin;
                        bcd_work   <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= CNT_LOAD;
                        o_busy     <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    bcd_work   <= bcd_next;
                    shift_reg  <= shift_next;
                    ovf_sticky <= ovf_sticky | bcd_adj[BCD_W-1];
                    cnt        <= cnt - CNT_ONE;
                    // This step consumes the last operand bit.
                    if (cnt == CNT_ONE) begin
                        o_busy <= 1'b0;
                        state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    o_bcd  <= bcd_work;
                    o_ovf  <= ovf_sticky;
                    o_done <= 1'b1;
                    state  <= ST_IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_bin_to_bcd_seq.sv
// tb/tb_module_bin_to_bcd_seq.sv - self-checking bench for module_bin_to_bcd_seq

module tb_module_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    logic        start2;
    logic [7:0]  bin2;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd2;
    logic        ovf2;

    int n_cmp;
    int n_bad;

    module_bin_to_bcd_seq #(.W_BIN(12), .N_DIG(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin(bin),
        .o_busy(busy), .o_done(done), .o_bcd(bcd), .o_ovf(ovf)
    );

    module_bin_to_bcd_seq #(.W_BIN(8), .N_DIG(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_bin(bin2),
        .o_busy(busy2), .o_done(done2), .o_bcd(bcd2), .o_ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits of v, lowest digit first, kept to n digits.
    function automatic logic [31:0] dec_bcd(input int v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Cycle-count model of the 12-bit/4-digit instance: a request is taken
    // only when no conversion is outstanding, busy spans 12 cycles, and the
    // result lands 13 edges after the accepting edge.
    int          m_p;
    int          m_val;
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_bcd;
    logic        m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p = -1; m_busy = 0; m_done = 0; m_bcd = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_p < 0) begin
                if (start) begin
                    m_val = int'(bin); m_p = 0; m_busy = 1;
                end
            end else begin
                m_p++;
                m_busy = (m_p < 12);
                if (m_p == 13) begin
                    m_done = 1;
                    m_bcd  = dec_bcd(m_val, 4)[15:0];
                    m_ovf  = (m_val >= 10000);
                    m_p    = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model busy", {31'd0, busy}, {31'd0, m_busy});
        check("model done", {31'd0, done}, {31'd0, m_done});
        check("model bcd",  {16'd0, bcd},  {16'd0, m_bcd});
        check("model ovf",  {31'd0, ovf},  {31'd0, m_ovf});
    end

    // Issue one request and wait for its result. If inject_at >= 0 a second
    // request with operand 999 is pulsed at that cycle and must be ignored.
    task automatic run(input logic [11:0] v, input logic [15:0] exp, input int inject_at);
        int cyc;
        int nbusy;
        int ndone;
        @(negedge clk);
        start = 1'b1; bin = v;
        cyc = 0; nbusy = 0; ndone = 0;
        while (ndone == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == inject_at) begin start = 1'b1; bin = 12'd999; end
            else begin start = 1'b0; end
            if (busy) nbusy++;
            if (done) ndone++;
        end
        check("done seen", ndone, 1);
        check("latency", cyc, 14);
        check("busy cycles", nbusy, 12);
        check("literal bcd", {16'd0, bcd}, {16'd0, exp});
        check("literal ovf", {31'd0, ovf}, 32'd0);
        if (inject_at >= 0) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) ndone++;
            end
            check("single done", ndone, 1);
            check("held bcd", {16'd0, bcd}, {16'd0, exp});
        end
    endtask

    task automatic run2(input logic [7:0] v, input logic [7:0] exp, input logic exp_ovf);
        int cyc;
        bit seen;
        @(negedge clk);
        start2 = 1'b1; bin2 = v;
        cyc = 0; seen = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            start2 = 1'b0;
            cyc++;
            if (done2) seen = 1;
        end
        check("w8 done seen", {31'd0, seen}, 32'd1);
        check("w8 latency", cyc, 10);
        check("w8 bcd", {24'd0, bcd2}, {24'd0, exp});
        check("w8 ovf", {31'd0, ovf2}, {31'd0, exp_ovf});
    endtask

    initial begin
        int ndone;
        int v;
        n_cmp = 0; n_bad = 0;
        start = 0; bin = 0; start2 = 0; bin2 = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset bcd",  {16'd0, bcd},  32'd0);
        check("reset ovf",  {31'd0, ovf},  32'd0);
        rst = 1'b0;

        // Model pins: hand-computed digit strings.
        check("pin 4095", dec_bcd(4095, 4), 32'h4095);
        check("pin 255/2", dec_bcd(255, 2), 32'h55);

        run(12'd4095, 16'h4095, -1);
        run(12'd0,    16'h0000, -1);
        run(12'd1000, 16'h1000, -1);
        run(12'd9,    16'h0009, -1);
        run(12'd1234, 16'h1234, 5);

        // Reset at SHIFT step 6 of 4000; outputs must drop without a clock edge.
        @(negedge clk);
        start = 1'b1; bin = 12'd4000;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async busy", {31'd0, busy}, 32'd0);
        check("async done", {31'd0, done}, 32'd0);
        check("async bcd",  {16'd0, bcd},  32'd0);
        check("async ovf",  {31'd0, ovf},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no done after reset", ndone, 0);
        run(12'd42, 16'h0042, -1);

        // Narrow instance: overflow keeps the low digits.
        run2(8'd255, 8'h55, 1'b1);
        run2(8'd99,  8'h99, 1'b0);
        run2(8'd100, 8'h00, 1'b1);

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 4095));
            run(12'(v), dec_bcd(v, 4)[15:0], -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
